// File: rtl/occupancy_counter.sv
// Occupancy counter: edge-detected entry/exit events move a saturating count
// between 0 and MAX_COUNT. The count, full/empty flags and the sticky
// overflow/underflow errors are all registered.
// Optional feature: define OCC_BCD_EN to build an incremental two-digit BCD
// mirror of the count. Without it, bcd_tens/bcd_ones are tied to zero.
module occupancy_counter #(
  parameter int unsigned MAX_COUNT = 20,
  parameter int unsigned CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entered,
  input  logic             exited,
  input  logic             clear_err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  // Edge-detector history; reset to 1 so a level held through reset is ignored
  logic entered_q, exited_q;

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic ent_evt, ext_evt;
  logic do_inc, do_dec;
  logic ovf_set, unf_set;

  // Rising-edge detection and event classification
  always_comb begin
    ent_evt = entered & ~entered_q;
    ext_evt = exited & ~exited_q;
    do_inc  = 1'b0;
    do_dec  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    // Simultaneous entry and exit cancel out, even at the limits
    if (ent_evt && !ext_evt) begin
      if (count_q == MaxCnt) begin
        ovf_set = 1'b1;
      end else begin
        do_inc = 1'b1;
      end
    end else if (ext_evt && !ent_evt) begin
      if (count_q == '0) begin
        unf_set = 1'b1;
      end else begin
        do_dec = 1'b1;
      end
    end
  end

  // Next-state for count, flags and sticky errors
  always_comb begin
    count_d = count_q;
    if (do_inc) begin
      count_d = count_q + OneCnt;
    end else if (do_dec) begin
      count_d = count_q - OneCnt;
    end
    // Flags derive from next count so they land on the same edge as count
    full_d  = (count_d == MaxCnt);
    empty_d = (count_d == '0);
    // A new error at the same edge as clear_err keeps the flag set
    ovf_d   = (ovf_q & ~clear_err) | ovf_set;
    unf_d   = (unf_q & ~clear_err) | unf_set;
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      entered_q <= 1'b1;
      exited_q  <= 1'b1;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      entered_q <= entered;
      exited_q  <= exited;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

`ifdef OCC_BCD_EN
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  // Incremental BCD tracking driven by the same inc/dec decisions as count
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (do_inc) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (do_dec) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  // BCD digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;
`else
  assign bcd_tens = 4'd0;
  assign bcd_ones = 4'd0;
`endif

endmodule

// File: tb/tb_occupancy_counter.sv
// Directed testbench for occupancy_counter with MAX_COUNT=20.
module tb_occupancy_counter;

  localparam int unsigned MaxCount = 20;
  localparam int unsigned CntW     = 7;

  logic            clk;
  logic            reset;
  logic            entered;
  logic            exited;
  logic            clear_err;
  logic [CntW-1:0] count;
  logic            full;
  logic            empty;
  logic            overflow_err;
  logic            underflow_err;
  logic [3:0]      bcd_tens;
  logic [3:0]      bcd_ones;

  int n_vec;
  int n_bad;

  occupancy_counter #(
    .MAX_COUNT(MaxCount),
    .CNT_W    (CntW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .entered      (entered),
    .exited       (exited),
    .clear_err    (clear_err),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input logic f, input logic e,
                         input logic ov, input logic un);
    int et, eo;
`ifdef OCC_BCD_EN
    et = c / 10;
    eo = c % 10;
`else
    et = 0;
    eo = 0;
`endif
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".ovf"}, 32'(overflow_err), 32'(ov));
    chk({tag, ".unf"}, 32'(underflow_err), 32'(un));
    chk({tag, ".tens"}, 32'(bcd_tens), 32'(et));
    chk({tag, ".ones"}, 32'(bcd_ones), 32'(eo));
  endtask

  task automatic pulse_in();
    entered = 1'b1;
    cyc(1);
    entered = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_out();
    exited = 1'b1;
    cyc(1);
    exited = 1'b0;
    cyc(1);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    entered   = 1'b0;
    exited    = 1'b0;
    clear_err = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk_all("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Three single-cycle entries
    repeat (3) pulse_in();
    chk_all("three_in", 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Held level counts once, visible one cycle after the rise
    entered = 1'b1;
    cyc(1);
    chk("hold_latency", 32'(count), 32'd4);
    cyc(4);
    chk("hold_5", 32'(count), 32'd4);
    entered = 1'b0;
    cyc(1);

    // BCD carry and borrow around 9/10
    repeat (5) pulse_in();
    chk_all("nine", 9, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_in();
    chk_all("ten", 10, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_out();
    chk_all("back_nine", 9, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill to capacity, then overflow
    repeat (11) pulse_in();
    chk_all("full20", 20, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_in();
    chk_all("overflow", 20, 1'b1, 1'b0, 1'b1, 1'b0);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    cyc(1);
    chk_all("ovf_cleared", 20, 1'b1, 1'b0, 1'b0, 1'b0);

    // Simultaneous entry and exit while full
    entered = 1'b1;
    exited  = 1'b1;
    cyc(1);
    entered = 1'b0;
    exited  = 1'b0;
    cyc(1);
    chk_all("simul_full", 20, 1'b1, 1'b0, 1'b0, 1'b0);

    // New error wins over clear at the same edge
    clear_err = 1'b1;
    entered   = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    entered   = 1'b0;
    cyc(1);
    chk_all("clr_vs_new", 20, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-burst with entered held high through release
    entered = 1'b1;
    reset   = 1'b1;
    cyc(2);
    chk_all("reset_burst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(3);
    chk("held_thru_reset", 32'(count), 32'd0);
    entered = 1'b0;
    cyc(1);
    entered = 1'b1;
    cyc(1);
    chk("rerise", 32'(count), 32'd1);
    entered = 1'b0;
    cyc(1);

    // Drain to empty, then underflow
    pulse_out();
    chk_all("to_zero", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_out();
    chk_all("underflow", 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Clear, then simultaneous events at empty raise nothing
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    entered   = 1'b1;
    exited    = 1'b1;
    cyc(1);
    entered = 1'b0;
    exited  = 1'b0;
    cyc(1);
    chk_all("simul_empty", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/occupancy_counter.md
OCCUPANCY_COUNTER -- requirements
Module: occupancy_counter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 20: capacity limit, legal range 1..99.
REQ-002 SHALL have parameter CNT_W, default 7: width of count, 2^CNT_W-1 >= MAX_COUNT.
REQ-003 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port entered  input  1  entry event from the upstream door FSM, level, may be held >1 cycle.
REQ-006 SHALL have port exited  input  1  exit event from the upstream door FSM, level, may be held >1 cycle.
REQ-007 SHALL have port clear_err  input  1  clears sticky error flags.
REQ-008 SHALL have port count  output  CNT_W  current occupancy, registered.
REQ-009 SHALL have port full  output  1  high when count == MAX_COUNT, registered.
REQ-010 SHALL have port empty  output  1  high when count == 0, registered.
REQ-011 SHALL have port overflow_err  output  1  sticky, entry attempted while full.
REQ-012 SHALL have port underflow_err  output  1  sticky, exit attempted while empty.
REQ-013 SHALL have port bcd_tens  output  4  tens digit of count in BCD.
REQ-014 SHALL have port bcd_ones  output  4  ones digit of count in BCD.

Function
REQ-015 SHALL register entered/exited history and detect rising edges: event = input high this edge and low at previous edge; a level held N cycles counts once.
REQ-016 SHALL apply an entry event at the same clock edge it is detected; count visible one cycle after input rises (latency 1).
REQ-017 SHALL increment count by 1 on an entry-only event when count < MAX_COUNT.
REQ-018 SHALL decrement count by 1 on an exit-only event when count > 0.
REQ-019 SHALL leave count unchanged and flag no error when entry and exit events occur at the same edge, including when full or empty.
REQ-020 SHALL hold count at MAX_COUNT and set overflow_err on an entry-only event while full.
REQ-021 SHALL hold count at 0 and set underflow_err on an exit-only event while empty.
REQ-022 SHALL clear both error flags on clear_err high; a new error at the same edge wins (flag stays set).
REQ-023 SHALL update full and empty at the same edge as count so all three are always consistent.
REQ-024 SHALL maintain bcd_tens/bcd_ones as an incremental BCD counter updated at the same edge as count (ones wraps 9->0 with tens carry, 0->9 with tens borrow); no divider.

Reset
REQ-025 SHALL on reset set count=0, empty=1, full=0, overflow_err=0, underflow_err=0, bcd_tens=0, bcd_ones=0.
REQ-026 SHALL on reset set edge-detector history to 1, so an input held high through reset release is not counted until it falls and rises again.
REQ-027 SHALL give reset priority over all events and clear_err, including mid-burst.

Configuration
REQ-028 SHALL compile BCD logic only when macro OCC_BCD_EN is defined; with it, REQ-024 applies; without it, bcd_tens and bcd_ones SHALL be tied to 0 and no BCD registers exist; count/full/empty/error behaviour identical in both builds.

Verification
REQ-029 SHALL verify: reset, then 3 single-cycle entered pulses -> count=3, empty=0, bcd_tens=0, bcd_ones=3 (OCC_BCD_EN).
REQ-030 SHALL verify: entered held high 5 cycles -> count increments by exactly 1.
REQ-031 SHALL verify: MAX_COUNT=20, 21 entry pulses -> count=20, full=1, overflow_err=1; clear_err pulse -> overflow_err=0, count=20.
REQ-032 SHALL verify: from reset, one exited pulse -> count=0, empty=1, underflow_err=1.
REQ-033 SHALL verify: count=20 (full), entered and exited rise same cycle -> count=20, no error; count 9 + one entry -> bcd_tens=1, bcd_ones=0, then one exit -> 0/9.
REQ-034 SHALL verify: entered held high while reset asserted then released -> count stays 0 until entered falls and rises, then count=1.
